// File: rtl/neopixel_pkg.sv
// Shared NeoPixel/WS2812 types and default timing constants, common to the
// encoders and the decoder (20 ns clock).
package neopixel_pkg;

  localparam int PIXEL_W         = 24;
  localparam int BIT_PERIOD_CYC  = 61;
  localparam int RESET_GAP_CYC   = 1250;
  localparam int T1_MIN_DEF_CYC  = 30;
  localparam int MIN_HIGH_DEF_CYC = 5;

  typedef enum logic [1:0] {
    ST_WAIT_GAP = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2,
    ST_LOW      = 2'd3
  } state_t;

  // Index width for a frame of n pixels, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neopixel_decoder_if.sv
// Decoded pixel stream from the NeoPixel decoder plus its FSM state for observation.
interface neopixel_decoder_if #(
  parameter int IDX_W = 2
);
  import neopixel_pkg::*;

  // pixel_valid, frame_done, bit_error and overflow are single-cycle strobes with
  // no back-pressure; pixel_data/pixel_index are meaningful when pixel_valid is high.
  logic [PIXEL_W-1:0] pixel_data;
  logic               pixel_valid;
  logic [IDX_W-1:0]   pixel_index;
  logic               frame_done;
  logic               bit_error;
  logic               overflow;
  state_t             state;

  modport master (
    output pixel_data, pixel_valid, pixel_index, frame_done, bit_error, overflow, state
  );

  modport slave (
    input pixel_data, pixel_valid, pixel_index, frame_done, bit_error, overflow, state
  );

endinterface

// File: rtl/neopixel_decoder_pulse_classifier.sv
// Synchronizes the data line and measures high/low run lengths, turning each
// falling edge into a bit, a glitch, and flagging over-long highs and reset gaps.
module pulse_classifier #(
  parameter int T1_MIN_CYC   = 30,
  parameter int MIN_HIGH_CYC = 5,
  parameter int MAX_HIGH_CYC = 61,
  parameter int RESET_CYC    = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic di_i,
  input  logic hold_low_i,
  output logic rise_o,
  output logic bit_strobe_o,
  output logic bit_value_o,
  output logic glitch_o,
  output logic too_long_o,
  output logic gap_strobe_o
);

  localparam int HCW = $clog2(MAX_HIGH_CYC + 2);
  localparam int LCW = $clog2(RESET_CYC + 1);
  localparam logic [HCW-1:0] H_SAT = HCW'(MAX_HIGH_CYC + 1);
  localparam logic [HCW-1:0] H_MAX = HCW'(MAX_HIGH_CYC);
  localparam logic [HCW-1:0] H_MIN = HCW'(MIN_HIGH_CYC);
  localparam logic [HCW-1:0] H_T1  = HCW'(T1_MIN_CYC);
  localparam logic [LCW-1:0] L_SAT = LCW'(RESET_CYC);
  localparam logic [LCW-1:0] L_GAP = LCW'(RESET_CYC - 1);

  logic           sync_q, di_s_q, di_prev_q;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic           rise, fall, glitch, bit_strobe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= 1'b0;
      di_s_q    <= 1'b0;
      di_prev_q <= 1'b0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
    end else begin
      sync_q    <= di_i;
      di_s_q    <= sync_q;
      di_prev_q <= di_s_q;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
    end
  end

  assign rise       = di_s_q & ~di_prev_q;
  assign fall       = ~di_s_q & di_prev_q;
  // On the falling-edge cycle hcnt_q holds the full high length of the pulse.
  assign glitch     = fall && (hcnt_q < H_MIN);
  assign bit_strobe = fall && !glitch;

  always_comb begin
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    if (rise) begin
      hcnt_d = HCW'(1);
    end else if (di_s_q && (hcnt_q != H_SAT)) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    // A high either restarts the low run or, while a pulse may yet prove to be
    // a glitch, freezes it so the run resumes afterwards.
    if (di_s_q) begin
      lcnt_d = hold_low_i ? lcnt_q : '0;
    end else if (bit_strobe) begin
      lcnt_d = LCW'(1);
    end else if (lcnt_q != L_SAT) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  assign rise_o       = rise;
  assign bit_strobe_o = bit_strobe;
  assign bit_value_o  = (hcnt_q >= H_T1);
  assign glitch_o     = glitch;
  assign too_long_o   = di_s_q && (hcnt_q >= H_MAX);
  assign gap_strobe_o = !di_s_q && !bit_strobe && (lcnt_q >= L_GAP);

endmodule

// File: rtl/neopixel_decoder.sv
// NeoPixel receive decoder: FSM, 24-bit shift register and per-frame pixel
// counter on top of the pulse classifier.
module neopixel_decoder
  import neopixel_pkg::*;
#(
  parameter int T1_MIN_CYC   = T1_MIN_DEF_CYC,
  parameter int MIN_HIGH_CYC = MIN_HIGH_DEF_CYC,
  parameter int MAX_HIGH_CYC = BIT_PERIOD_CYC,
  parameter int RESET_CYC    = RESET_GAP_CYC,
  parameter int MAX_PIXELS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic DI,
  neopixel_decoder_if.master px
);

  localparam int IDX_W = idx_width(MAX_PIXELS);
  localparam int PCW   = $clog2(MAX_PIXELS + 1);
  localparam int BCW   = $clog2(PIXEL_W);
  localparam logic [PCW-1:0] P_MAX  = PCW'(MAX_PIXELS);
  localparam logic [BCW-1:0] B_LAST = BCW'(PIXEL_W - 1);

  logic rise, bit_strobe, bit_value, glitch, too_long, gap_strobe;

  state_t             state_q, state_d;
  logic [PIXEL_W-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_flag_q, ovf_flag_d, from_low_q, from_low_d;
  logic               pv_q, pv_d, fd_q, fd_d, err_q, err_d, ov_q, ov_d;

  pulse_classifier #(
    .T1_MIN_CYC  (T1_MIN_CYC),
    .MIN_HIGH_CYC(MIN_HIGH_CYC),
    .MAX_HIGH_CYC(MAX_HIGH_CYC),
    .RESET_CYC   (RESET_CYC)
  ) u_cls (
    .clk         (clk),
    .rst_n       (rst_n),
    .di_i        (DI),
    .hold_low_i  (state_q != ST_WAIT_GAP),
    .rise_o      (rise),
    .bit_strobe_o(bit_strobe),
    .bit_value_o (bit_value),
    .glitch_o    (glitch),
    .too_long_o  (too_long),
    .gap_strobe_o(gap_strobe)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT_GAP;
      shift_q    <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      idx_q      <= '0;
      ovf_flag_q <= 1'b0;
      from_low_q <= 1'b0;
      pv_q       <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      idx_q      <= idx_d;
      ovf_flag_q <= ovf_flag_d;
      from_low_q <= from_low_d;
      pv_q       <= pv_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
      ov_q       <= ov_d;
    end
  end

  assign word = {shift_q[PIXEL_W-2:0], bit_value};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    idx_d      = idx_q;
    ovf_flag_d = ovf_flag_q;
    from_low_d = from_low_q;
    pv_d       = 1'b0;
    fd_d       = 1'b0;
    err_d      = 1'b0;
    ov_d       = 1'b0;
    unique case (state_q)
      ST_WAIT_GAP: begin
        if (gap_strobe) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_HIGH;
          from_low_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (too_long) begin
          err_d      = 1'b1;
          state_d    = ST_WAIT_GAP;
          shift_d    = '0;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_flag_d = 1'b0;
        end else if (glitch) begin
          state_d = from_low_q ? ST_LOW : ST_IDLE;
        end else if (bit_strobe) begin
          state_d = ST_LOW;
          if (bit_cnt_q == B_LAST) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            if (pix_cnt_q < P_MAX) begin
              data_d = word;
              idx_d  = pix_cnt_q[IDX_W-1:0];
              pv_d   = 1'b1;
            end else begin
              ovf_flag_d = 1'b1;
            end
            if (pix_cnt_q != P_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
          end else begin
            shift_d   = word;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          from_low_d = 1'b1;
        end else if (gap_strobe) begin
          fd_d       = 1'b1;
          ov_d       = ovf_flag_q;
          err_d      = (bit_cnt_q != '0);
          shift_d    = '0;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_flag_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_GAP;
    endcase
  end

  assign px.pixel_data  = data_q;
  assign px.pixel_valid = pv_q;
  assign px.pixel_index = idx_q;
  assign px.frame_done  = fd_q;
  assign px.bit_error   = err_q;
  assign px.overflow    = ov_q;
  assign px.state       = state_q;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Self-checking bench for neopixel_decoder: directed frames plus randomized
// frames compared against a frame-level model of the decoded stream.
module tb_neopixel_decoder;
  import neopixel_pkg::*;

  localparam int T1    = 30;
  localparam int MINH  = 5;
  localparam int MAXH  = 61;
  localparam int RST   = 1250;
  localparam int MAXP  = 4;
  localparam int IDX_W = idx_width(MAXP);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic di = 1'b0;
  int   cyc = 0;
  int   last_fall = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neopixel_decoder_if #(.IDX_W(IDX_W)) px ();

  neopixel_decoder #(
    .T1_MIN_CYC  (T1),
    .MIN_HIGH_CYC(MINH),
    .MAX_HIGH_CYC(MAXH),
    .RESET_CYC   (RST),
    .MAX_PIXELS  (MAXP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .DI   (di),
    .px   (px)
  );

  // Scoreboard: captured DUT events and the expected pixel queue
  logic [23:0] exp_q[$];
  logic [23:0] got_data[$];
  int          got_idx[$];
  int          pv_cyc[$];
  int          fd_cyc[$];
  int          err_n, ovf_n, ovf_fd_n;

  always @(negedge clk) begin
    if (rst_n) begin
      if (px.pixel_valid) begin
        got_data.push_back(px.pixel_data);
        got_idx.push_back(int'(px.pixel_index));
        pv_cyc.push_back(cyc);
      end
      if (px.frame_done) fd_cyc.push_back(cyc);
      if (px.bit_error) err_n++;
      if (px.overflow) ovf_n++;
      if (px.overflow && px.frame_done) ovf_fd_n++;
    end
  end

  task automatic clear_capture();
    got_data.delete(); got_idx.delete(); pv_cyc.delete(); fd_cyc.delete();
    exp_q.delete();
    err_n = 0; ovf_n = 0; ovf_fd_n = 0;
  endtask

  // Driver tasks; all start and end on a falling clock edge
  task automatic send_pulse(input int hi, input int lo);
    di = 1'b1;
    repeat (hi) @(negedge clk);
    di = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_std_bit(input logic v);
    send_pulse(v ? 40 : 20, v ? 21 : 41);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_std_bit(w[i]);
  endtask

  task automatic gap(input int n);
    di = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rand_bit(input logic v);
    int hi;
    hi = v ? int'($urandom_range(MAXH, T1)) : int'($urandom_range(T1 - 1, MINH));
    send_pulse(hi, int'($urandom_range(30, 5)));
    if ($urandom_range(7, 0) == 0)
      send_pulse(int'($urandom_range(MINH - 1, 1)), int'($urandom_range(30, 5)));
  endtask

  task automatic test_reset();
    n_cmp++; if (px.pixel_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", px.pixel_data); end
    n_cmp++; if (px.pixel_index !== '0) begin n_bad++; $display("FAIL reset_index: got %0d want 0", px.pixel_index); end
    n_cmp++; if ({px.pixel_valid, px.frame_done, px.bit_error, px.overflow} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000", {px.pixel_valid, px.frame_done, px.bit_error, px.overflow}); end
    n_cmp++; if (px.state !== ST_WAIT_GAP) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", px.state, ST_WAIT_GAP); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (px.state !== ST_WAIT_GAP) begin n_bad++; $display("FAIL reset_release_state: got %0d want %0d", px.state, ST_WAIT_GAP); end
  endtask

  task automatic test_no_gap();
    clear_capture();
    send_word(24'h00FF00);
    gap(300);
    n_cmp++; if (got_data.size() != 0 || fd_cyc.size() != 0) begin
      n_bad++; $display("FAIL no_gap_output: got pv=%0d fd=%0d want 0/0", got_data.size(), fd_cyc.size()); end
    n_cmp++; if (px.state !== ST_WAIT_GAP) begin n_bad++; $display("FAIL no_gap_state: got %0d want %0d", px.state, ST_WAIT_GAP); end
  endtask

  task automatic test_single();
    int t24;
    clear_capture();
    gap(1260);
    n_cmp++; if (px.state !== ST_IDLE) begin n_bad++; $display("FAIL single_armed: got %0d want %0d", px.state, ST_IDLE); end
    send_word(24'h00FF00);
    t24 = last_fall;
    gap(1300);
    n_cmp++; if (got_data.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_data.size()); end
    if (got_data.size() > 0) begin
      n_cmp++; if (got_data[0] !== 24'h00FF00) begin n_bad++; $display("FAIL single_data: got %h want 00ff00", got_data[0]); end
      n_cmp++; if (got_idx[0] != 0) begin n_bad++; $display("FAIL single_index: got %0d want 0", got_idx[0]); end
      n_cmp++; if (pv_cyc[0] != t24 + 3) begin n_bad++; $display("FAIL single_pv_latency: got %0d want %0d", pv_cyc[0] - t24, 3); end
    end
    n_cmp++; if (fd_cyc.size() != 1) begin n_bad++; $display("FAIL single_fd_count: got %0d want 1", fd_cyc.size()); end
    if (fd_cyc.size() > 0) begin
      n_cmp++; if (fd_cyc[0] != t24 + RST + 2) begin n_bad++; $display("FAIL single_fd_latency: got %0d want %0d", fd_cyc[0] - t24, RST + 2); end
    end
    n_cmp++; if (err_n != 0 || ovf_n != 0) begin n_bad++; $display("FAIL single_flags: got err=%0d ovf=%0d want 0/0", err_n, ovf_n); end
  endtask

  task automatic test_frame(input string name, input int npix);
    logic [23:0] tbl[5];
    tbl = '{24'h00FF00, 24'hFF00FF, 24'hBDC345, 24'h1B4322, 24'h123456};
    clear_capture();
    for (int p = 0; p < npix; p++) send_word(tbl[p]);
    gap(1300);
    for (int p = 0; p < npix && p < MAXP; p++) exp_q.push_back(tbl[p]);
    n_cmp++; if (got_data.size() != exp_q.size()) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_q[i] || got_idx[i] != i) begin
        n_bad++; $display("FAIL %s_pixel%0d: got %h@%0d want %h@%0d", name, i, got_data[i], got_idx[i], exp_q[i], i); end
    end
    n_cmp++; if (fd_cyc.size() != 1) begin n_bad++; $display("FAIL %s_fd: got %0d want 1", name, fd_cyc.size()); end
    n_cmp++; if (ovf_n != (npix > MAXP ? 1 : 0) || ovf_fd_n != ovf_n) begin
      n_bad++; $display("FAIL %s_overflow: got ovf=%0d with_fd=%0d want %0d", name, ovf_n, ovf_fd_n, npix > MAXP ? 1 : 0); end
    n_cmp++; if (err_n != 0) begin n_bad++; $display("FAIL %s_err: got %0d want 0", name, err_n); end
  endtask

  task automatic test_glitch();
    logic [23:0] w;
    w = 24'hA5C33C;
    clear_capture();
    send_pulse(3, 30);
    for (int i = 23; i >= 0; i--) begin
      if (i == 12) begin
        send_pulse(w[i] ? 40 : 20, 15);
        send_pulse(3, 20);
      end else begin
        send_std_bit(w[i]);
      end
    end
    gap(1300);
    n_cmp++; if (got_data.size() != 1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", got_data.size()); end
    if (got_data.size() > 0) begin
      n_cmp++; if (got_data[0] !== w) begin n_bad++; $display("FAIL glitch_data: got %h want %h", got_data[0], w); end
    end
    n_cmp++; if (err_n != 0 || fd_cyc.size() != 1) begin n_bad++; $display("FAIL glitch_flags: got err=%0d fd=%0d want 0/1", err_n, fd_cyc.size()); end
  endtask

  task automatic test_too_long();
    clear_capture();
    for (int i = 0; i < 5; i++) send_std_bit(1'b1);
    send_pulse(80, 41);
    n_cmp++; if (err_n != 1) begin n_bad++; $display("FAIL long_err: got %0d want 1", err_n); end
    n_cmp++; if (px.state !== ST_WAIT_GAP) begin n_bad++; $display("FAIL long_state: got %0d want %0d", px.state, ST_WAIT_GAP); end
    send_word(24'h00FF00);
    gap(1300);
    n_cmp++; if (got_data.size() != 0 || fd_cyc.size() != 0) begin
      n_bad++; $display("FAIL long_locked: got pv=%0d fd=%0d want 0/0", got_data.size(), fd_cyc.size()); end
    send_word(24'h5A5A5A);
    gap(1300);
    n_cmp++; if (got_data.size() != 1 || fd_cyc.size() != 1) begin
      n_bad++; $display("FAIL long_rearm: got pv=%0d fd=%0d want 1/1", got_data.size(), fd_cyc.size()); end
    if (got_data.size() > 0) begin
      n_cmp++; if (got_data[0] !== 24'h5A5A5A) begin n_bad++; $display("FAIL long_rearm_data: got %h want 5a5a5a", got_data[0]); end
    end
  endtask

  task automatic test_partial();
    clear_capture();
    for (int i = 0; i < 10; i++) send_std_bit(i[0]);
    gap(1300);
    n_cmp++; if (got_data.size() != 0) begin n_bad++; $display("FAIL partial_pv: got %0d want 0", got_data.size()); end
    n_cmp++; if (fd_cyc.size() != 1 || err_n != 1) begin n_bad++; $display("FAIL partial_flags: got fd=%0d err=%0d want 1/1", fd_cyc.size(), err_n); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] w;
    w = 24'hC0FFEE;
    clear_capture();
    for (int i = 23; i >= 14; i--) send_std_bit(w[i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (px.state !== ST_WAIT_GAP || px.pixel_data !== 24'h0) begin
      n_bad++; $display("FAIL rstmid_state: got st=%0d data=%h want %0d/000000", px.state, px.pixel_data, ST_WAIT_GAP); end
    for (int i = 13; i >= 0; i--) send_std_bit(w[i]);
    send_word(w);
    gap(1300);
    n_cmp++; if (got_data.size() != 0 || fd_cyc.size() != 0 || err_n != 0) begin
      n_bad++; $display("FAIL rstmid_silent: got pv=%0d fd=%0d err=%0d want 0/0/0", got_data.size(), fd_cyc.size(), err_n); end
    send_word(w);
    gap(1300);
    n_cmp++; if (got_data.size() != 1 || fd_cyc.size() != 1) begin
      n_bad++; $display("FAIL rstmid_rearm: got pv=%0d fd=%0d want 1/1", got_data.size(), fd_cyc.size()); end
    if (got_data.size() > 0) begin
      n_cmp++; if (got_data[0] !== w || got_idx[0] != 0) begin
        n_bad++; $display("FAIL rstmid_data: got %h@%0d want %h@0", got_data[0], got_idx[0], w); end
    end
  endtask

  task automatic test_random();
    int          npix, extra;
    logic [23:0] words[$];
    logic [23:0] w;
    for (int f = 0; f < 5; f++) begin
      clear_capture();
      words.delete();
      npix  = int'($urandom_range(6, 1));
      extra = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      for (int p = 0; p < npix; p++) begin
        w = 24'($urandom());
        words.push_back(w);
        for (int i = 23; i >= 0; i--) send_rand_bit(w[i]);
      end
      for (int i = 0; i < extra; i++) send_rand_bit(1'($urandom_range(1, 0)));
      gap(int'($urandom_range(1400, 1260)));
      // Frame-level model: whole words in order, capped at MAXP; leftovers are an error
      for (int p = 0; p < npix && p < MAXP; p++) exp_q.push_back(words[p]);
      n_cmp++; if (got_data.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", f, got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
        n_cmp++; if (got_data[i] !== exp_q[i] || got_idx[i] != i) begin
          n_bad++; $display("FAIL rand%0d_pixel%0d: got %h@%0d want %h@%0d", f, i, got_data[i], got_idx[i], exp_q[i], i); end
      end
      n_cmp++; if (fd_cyc.size() != 1 || err_n != (extra != 0 ? 1 : 0)) begin
        n_bad++; $display("FAIL rand%0d_fd_err: got fd=%0d err=%0d want 1/%0d", f, fd_cyc.size(), err_n, extra != 0 ? 1 : 0); end
      n_cmp++; if (ovf_n != (npix > MAXP ? 1 : 0) || ovf_fd_n != ovf_n) begin
        n_bad++; $display("FAIL rand%0d_ovf: got %0d/%0d want %0d", f, ovf_n, ovf_fd_n, npix > MAXP ? 1 : 0); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    di    = 1'b0;
    clear_capture();
    repeat (3) @(negedge clk);
    test_reset();
    test_no_gap();
    test_single();
    test_frame("four", 4);
    test_frame("five", 5);
    test_glitch();
    test_too_long();
    test_partial();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
